// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin scheduler sharing one external combinational
// single-precision multiplier among NREQ requesters. Granted operands are
// registered into a one-deep issue stage that drives the multiplier. The
// multiplier result is captured into a one-entry response slot per requester.
// Optional feature macro: FP_MUL_ARB_STICKY_EN adds sticky per-requester
// overflow/underflow status with a per-requester clear input.

module fp_mul_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_x,
    input  logic [NREQ*32-1:0]   req_y,
    input  logic [NREQ*3-1:0]    req_rmode,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    output logic [2:0]           mul_rmode,
    input  logic [31:0]          mul_z,
    input  logic                 mul_ovrf,
    input  logic                 mul_udrf,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*32-1:0]   rsp_z,
    output logic [NREQ-1:0]      rsp_ovrf,
    output logic [NREQ-1:0]      rsp_udrf,
    output logic                 busy
`ifdef FP_MUL_ARB_STICKY_EN
    ,
    input  logic [NREQ-1:0]      flag_clr,
    output logic [NREQ-1:0]      flag_ovrf,
    output logic [NREQ-1:0]      flag_udrf
`endif
);

    // Requester index width; NREQ is limited to 2..4.
    localparam int IDW = (NREQ > 2) ? 2 : 1;

    // Issue stage
    logic                 r_opValid;
    logic [IDW-1:0]       r_opId;
    logic [31:0]          r_opX;
    logic [31:0]          r_opY;
    logic [2:0]           r_opRmode;

    // Round-robin pointer
    logic [IDW-1:0]       r_ptr;

    // Response slots
    logic [NREQ-1:0]      r_rspValid;
    logic [NREQ*32-1:0]   r_rspZ;
    logic [NREQ-1:0]      r_rspOvrf;
    logic [NREQ-1:0]      r_rspUdrf;

    // Combinational arbitration signals
    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_complete;
    logic                 w_grantValid;
    logic [IDW-1:0]       w_grantId;
    logic [31:0]          w_selX;
    logic [31:0]          w_selY;
    logic [2:0]           w_selRmodeRaw;
    logic [2:0]           w_selRmode;

    // A requester may issue when it is valid, has nothing in the issue stage,
    // and its response slot is empty or being consumed this cycle.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i]
                      && !(r_opValid && (r_opId == IDW'(i)))
                      && (!r_rspValid[i] || rsp_ready[i]);
        end
    end

    // The issue stage completes into the slot of its owner on the next edge.
    always_comb begin
        w_complete = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_complete[i] = r_opValid && (r_opId == IDW'(i));
        end
    end

    // First eligible requester scanning upward from the pointer, wrapping at NREQ.
    // Offset k from the pointer lands on requester j when ptr == (j - k) mod NREQ.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_grantValid && w_elig[j]
                    && (r_ptr == IDW'((j - k + NREQ) % NREQ))) begin
                    w_grantValid = 1'b1;
                    w_grantId    = IDW'(j);
                end
            end
        end
    end

    // One-hot ready for the granted requester, suppressed while in reset.
    always_comb begin
        req_ready = '0;
        if (w_grantValid && !rst) begin
            for (int j = 0; j < NREQ; j++) begin
                req_ready[j] = (w_grantId == IDW'(j));
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_selX        = '0;
        w_selY        = '0;
        w_selRmodeRaw = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grantId == IDW'(j)) begin
                w_selX        = req_x[j*32 +: 32];
                w_selY        = req_y[j*32 +: 32];
                w_selRmodeRaw = req_rmode[j*3 +: 3];
            end
        end
    end

    // Rounding modes 5..7 are undefined for the multiplier; fall back to RNE.
    always_comb begin
        w_selRmode = (w_selRmodeRaw > 3'd4) ? 3'd0 : w_selRmodeRaw;
    end

    // Issue stage: load the granted operation, otherwise go empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opValid <= 1'b0;
            r_opId    <= '0;
            r_opX     <= '0;
            r_opY     <= '0;
            r_opRmode <= '0;
        end else begin
            r_opValid <= w_grantValid;
            if (w_grantValid) begin
                r_opId    <= w_grantId;
                r_opX     <= w_selX;
                r_opY     <= w_selY;
                r_opRmode <= w_selRmode;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grantValid) begin
            r_ptr <= (w_grantId == IDW'(NREQ - 1)) ? '0 : (w_grantId + 1'b1);
        end
    end

    // Response slots: a completion fills the slot and takes priority over a
    // same-edge consume, so the slot stays valid with the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspValid <= '0;
            r_rspZ     <= '0;
            r_rspOvrf  <= '0;
            r_rspUdrf  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_complete[i]) begin
                    r_rspValid[i]        <= 1'b1;
                    r_rspZ[i*32 +: 32]   <= mul_z;
                    r_rspOvrf[i]         <= mul_ovrf;
                    r_rspUdrf[i]         <= mul_udrf;
                end else if (r_rspValid[i] && rsp_ready[i]) begin
                    r_rspValid[i]        <= 1'b0;
                end
            end
        end
    end

`ifdef FP_MUL_ARB_STICKY_EN
    logic [NREQ-1:0] r_flagOvrf;
    logic [NREQ-1:0] r_flagUdrf;

    // Sticky exception status: a completion raising a flag beats a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flagOvrf <= '0;
            r_flagUdrf <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_complete[i] && mul_ovrf) begin
                    r_flagOvrf[i] <= 1'b1;
                end else if (flag_clr[i]) begin
                    r_flagOvrf[i] <= 1'b0;
                end
                if (w_complete[i] && mul_udrf) begin
                    r_flagUdrf[i] <= 1'b1;
                end else if (flag_clr[i]) begin
                    r_flagUdrf[i] <= 1'b0;
                end
            end
        end
    end

    assign flag_ovrf = r_flagOvrf;
    assign flag_udrf = r_flagUdrf;
`endif

    assign mul_x     = r_opX;
    assign mul_y     = r_opY;
    assign mul_rmode = r_opRmode;
    assign rsp_valid = r_rspValid;
    assign rsp_z     = r_rspZ;
    assign rsp_ovrf  = r_rspOvrf;
    assign rsp_udrf  = r_rspUdrf;
    assign busy      = r_opValid || (|r_rspValid);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter with NREQ=3. A table-driven stand-in for the
// external fp_mul supplies results for the directed operand pairs; expected
// responses are pushed per requester at acceptance and popped by a monitor
// whenever a response slot is consumed.

module tb_fp_mul_arbiter;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_x;
    logic [NREQ*32-1:0]   req_y;
    logic [NREQ*3-1:0]    req_rmode;
    logic [31:0]          mul_x;
    logic [31:0]          mul_y;
    logic [2:0]           mul_rmode;
    logic [31:0]          mul_z;
    logic                 mul_ovrf;
    logic                 mul_udrf;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ*32-1:0]   rsp_z;
    logic [NREQ-1:0]      rsp_ovrf;
    logic [NREQ-1:0]      rsp_udrf;
    logic                 busy;
`ifdef FP_MUL_ARB_STICKY_EN
    logic [NREQ-1:0]      flag_clr;
    logic [NREQ-1:0]      flag_ovrf;
    logic [NREQ-1:0]      flag_udrf;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    // Expected responses per requester, packed as {ovrf, udrf, z}
    logic [33:0] expQ0[$];
    logic [33:0] expQ1[$];
    logic [33:0] expQ2[$];

    logic [33:0] monExp;
    logic        monHave;

    int          rrOrder[4];
    logic [33:0] rrExp[4];

    fp_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_rmode (req_rmode),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_rmode (mul_rmode),
        .mul_z     (mul_z),
        .mul_ovrf  (mul_ovrf),
        .mul_udrf  (mul_udrf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_ovrf  (rsp_ovrf),
        .rsp_udrf  (rsp_udrf),
        .busy      (busy)
`ifdef FP_MUL_ARB_STICKY_EN
        ,
        .flag_clr  (flag_clr),
        .flag_ovrf (flag_ovrf),
        .flag_udrf (flag_udrf)
`endif
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Stand-in multiplier: known products for the directed operand pairs;
    // an out-of-range rounding mode yields an obviously wrong result.
    function automatic logic [33:0] mulModel(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] rm);
        if (rm > 3'd4) return {2'b00, 32'hDEADBEEF};
        case ({x, y})
            {32'h40400000, 32'h40400000}: return {2'b00, 32'h41100000};
            {32'h3f800000, 32'h40490fdb}: return {2'b00, 32'h40490fdb};
            {32'h7f000000, 32'h7f000000}: return {2'b10, 32'h7f800000};
            {32'h00800000, 32'h00800000}: return {2'b01, 32'h00000000};
            {32'h40000000, 32'h40400000}: return {2'b00, 32'h40c00000};
            {32'h40400000, 32'h40000000}: return {2'b00, 32'h40c00000};
            {32'h40000000, 32'h40000000}: return {2'b00, 32'h40800000};
            {32'h3f800000, 32'h40000000}: return {2'b00, 32'h40000000};
            {32'h40800000, 32'h3f000000}: return {2'b00, 32'h40000000};
            {32'h40800000, 32'h40800000}: return {2'b00, 32'h41800000};
            default:                      return {2'b00, 32'hBAD0BAD0};
        endcase
    endfunction

    // Drive the multiplier outputs from the registered operands
    always_comb begin
        {mul_ovrf, mul_udrf, mul_z} = mulModel(mul_x, mul_y, mul_rmode);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int id, input logic [33:0] v);
        case (id)
            0:       expQ0.push_back(v);
            1:       expQ1.push_back(v);
            default: expQ2.push_back(v);
        endcase
    endtask

    task automatic clearQueues();
        expQ0.delete();
        expQ1.delete();
        expQ2.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearQueues();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one operation and wait (bounded) for its grant; returns one
    // time unit after the accepting edge.
    task automatic applyStimulus(input int id, input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] rm, input logic [33:0] expv);
        bit got;
        got = 1'b0;
        req_x[id*32 +: 32]  = x;
        req_y[id*32 +: 32]  = y;
        req_rmode[id*3 +: 3] = rm;
        req_valid[id]       = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                pushExp(id, expv);
            end
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        if (!got) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL grant_timeout req%0d: got no grant, expected grant within 20 cycles", id);
        end
    endtask

    // Monitor: every consumed response is checked against its queue head
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    monHave = 1'b1;
                    monExp  = '0;
                    case (i)
                        0: if (expQ0.size() == 0) monHave = 1'b0; else monExp = expQ0.pop_front();
                        1: if (expQ1.size() == 0) monHave = 1'b0; else monExp = expQ1.pop_front();
                        default: if (expQ2.size() == 0) monHave = 1'b0; else monExp = expQ2.pop_front();
                    endcase
                    if (!monHave) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL rsp%0d_unexpected: got response z=0x%08h, expected none",
                                 i, rsp_z[i*32 +: 32]);
                    end else begin
                        checkOutput($sformatf("rsp%0d_z", i), rsp_z[i*32 +: 32], monExp[31:0]);
                        checkOutput($sformatf("rsp%0d_ovrf", i), 32'(rsp_ovrf[i]), 32'(monExp[33]));
                        checkOutput($sformatf("rsp%0d_udrf", i), 32'(rsp_udrf[i]), 32'(monExp[32]));
                    end
                end
            end
        end
    end

    // Runaway guard
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 50000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_rmode = '0;
        rsp_ready = '1;
`ifdef FP_MUL_ARB_STICKY_EN
        flag_clr  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with requests presented while reset is held
        req_valid = '1;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_busy",      32'(busy),      32'h0);
        checkOutput("reset_mul_x",     mul_x,          32'h0);
        checkOutput("reset_mul_rmode", 32'(mul_rmode), 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op and its two-cycle latency
        applyStimulus(0, 32'h40400000, 32'h40400000, 3'd1, {2'b00, 32'h41100000});
        @(negedge clk);
        checkOutput("single_mul_x",      mul_x,                32'h40400000);
        checkOutput("single_mul_rmode",  32'(mul_rmode),       32'h1);
        checkOutput("single_early_rsp",  32'(rsp_valid[0]),    32'h0);
        @(negedge clk);
        checkOutput("single_rsp_valid",  32'(rsp_valid[0]),    32'h1);
        idle(2);

        // Illegal rounding mode is replaced by RNE
        applyStimulus(0, 32'h3f800000, 32'h40490fdb, 3'd7, {2'b00, 32'h40490fdb});
        @(negedge clk);
        checkOutput("illegal_rmode", 32'(mul_rmode), 32'h0);
        idle(2);

        // Overflow result, then the sticky flag if present
        applyStimulus(0, 32'h7f000000, 32'h7f000000, 3'd0, {2'b10, 32'h7f800000});
        idle(3);
`ifdef FP_MUL_ARB_STICKY_EN
        @(negedge clk);
        checkOutput("sticky_ovrf_held", 32'(flag_ovrf[0]), 32'h1);
        @(posedge clk);
        #1;
        flag_clr[0] = 1'b1;
        @(posedge clk);
        #1;
        flag_clr[0] = 1'b0;
        @(negedge clk);
        checkOutput("sticky_ovrf_cleared", 32'(flag_ovrf[0]), 32'h0);
        #1;
`endif

        // Underflow on requester 2
        applyStimulus(2, 32'h00800000, 32'h00800000, 3'd2, {2'b01, 32'h00000000});
        idle(3);
`ifdef FP_MUL_ARB_STICKY_EN
        @(negedge clk);
        checkOutput("sticky_udrf2", 32'(flag_udrf[2]), 32'h1);
        #1;
`endif

        // Backpressure on slot 1
        rsp_ready[1] = 1'b0;
        applyStimulus(1, 32'h40000000, 32'h40400000, 3'd0, {2'b00, 32'h40c00000});
        idle(1);
        @(negedge clk);
        checkOutput("bp_slot1_full", 32'(rsp_valid[1]), 32'h1);
        @(posedge clk);
        #1;
        req_x[31:0]  = 32'h40000000;
        req_y[31:0]  = 32'h40000000;
        req_rmode[2:0] = 3'd0;
        req_valid[0] = 1'b1;
        req_x[63:32] = 32'h3f800000;
        req_y[63:32] = 32'h40000000;
        req_rmode[5:3] = 3'd0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("bp_grant_req0", 32'(req_ready), 32'h1);
        pushExp(0, {2'b00, 32'h40800000});
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("bp_req1_blocked", 32'(req_ready), 32'h0);
        checkOutput("bp_slot1_stable", rsp_z[63:32], 32'h40c00000);
        @(posedge clk);
        #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_grant", 32'(req_ready), 32'h2);
        pushExp(1, {2'b00, 32'h40000000});
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        idle(4);

        // Round robin: all three valid right after reset, then requester 0 again
        doReset();
        rrOrder[0] = 0; rrExp[0] = {2'b00, 32'h40c00000};
        rrOrder[1] = 1; rrExp[1] = {2'b00, 32'h40000000};
        rrOrder[2] = 2; rrExp[2] = {2'b00, 32'h41100000};
        rrOrder[3] = 0; rrExp[3] = {2'b00, 32'h40000000};
        req_x     = {32'h40400000, 32'h40800000, 32'h40400000};
        req_y     = {32'h40400000, 32'h3f000000, 32'h40000000};
        req_rmode = '0;
        req_valid = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(1) << rrOrder[c]);
            pushExp(rrOrder[c], rrExp[c]);
            @(posedge clk);
            #1;
            if (c == 0) begin
                req_x[31:0] = 32'h3f800000;
                req_y[31:0] = 32'h40000000;
            end else begin
                req_valid[rrOrder[c]] = 1'b0;
            end
        end
        idle(4);

        // Reset one cycle after accept drops the buffered result
        rsp_ready[1] = 1'b0;
        applyStimulus(1, 32'h40000000, 32'h40000000, 3'd0, {2'b00, 32'h40800000});
        @(posedge clk);
        #1;
        rst = 1'b1;
        clearQueues();
        req_x[31:0]  = 32'h40800000;
        req_y[31:0]  = 32'h40800000;
        req_valid[0] = 1'b1;
        req_x[95:64] = 32'h40000000;
        req_y[95:64] = 32'h40000000;
        req_valid[2] = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready_low", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_dropped",   32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy",       32'(busy),      32'h0);
        checkOutput("rst_rsp_valid",  32'(rsp_valid), 32'h0);
        checkOutput("rst_next_grant", 32'(req_ready), 32'h1);
        pushExp(0, {2'b00, 32'h41800000});
        @(posedge clk);
        #1;
        req_valid = '0;
        idle(6);

        // Every expected response must have been delivered
        checkOutput("drain_q0", 32'(expQ0.size()), 32'h0);
        checkOutput("drain_q1", 32'(expQ1.size()), 32'h0);
        checkOutput("drain_q2", 32'(expQ2.size()), 32'h0);
        checkOutput("final_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
